// File: rtl/silu_input_requant.sv
// Rounds/saturates PARALLELISM wide signed lanes into the 6-bit SiLU LUT index format.
// Latency 2 cycles; ready is combinational from downstream ready, so it stalls without bubbles.
module silu_input_requant #(
    parameter int DATA_IN_WIDTH       = 16,
    parameter int DATA_IN_FRAC_WIDTH  = 8,
    parameter int DATA_OUT_WIDTH      = 6,
    parameter int DATA_OUT_FRAC_WIDTH = 3,
    parameter int PARALLELISM         = 4,
    parameter int SAT_CNT_WIDTH       = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [PARALLELISM*DATA_IN_WIDTH-1:0]    data_in_0,
    input  logic                                    data_in_0_valid,
    output logic                                    data_in_0_ready,
    output logic [PARALLELISM*DATA_OUT_WIDTH-1:0]   data_out_0,
    output logic                                    data_out_0_valid,
    input  logic                                    data_out_0_ready,
    output logic                                    data_out_0_sat,
    input  logic                                    sat_clear,
    output logic [SAT_CNT_WIDTH-1:0]                sat_count
);

    localparam int SHIFT = DATA_IN_FRAC_WIDTH - DATA_OUT_FRAC_WIDTH;
    localparam int RW    = DATA_IN_WIDTH + 1;

    localparam logic signed [RW-1:0] MAXV = RW'(2**(DATA_OUT_WIDTH-1) - 1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    generate
        if (DATA_IN_FRAC_WIDTH < DATA_OUT_FRAC_WIDTH) begin : g_bad_frac
            $error("DATA_IN_FRAC_WIDTH must be >= DATA_OUT_FRAC_WIDTH");
        end
    endgenerate

    logic s1_en, s2_en;
    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;
    logic [PARALLELISM-1:0][RW-1:0]               s1_r_q, s1_r_d;
    logic [PARALLELISM*DATA_OUT_WIDTH-1:0]        s2_dat_q, s2_dat_d;
    logic                                         s2_sat_q, s2_sat_d;
    logic [PARALLELISM-1:0]                       lane_sat;
    logic [SAT_CNT_WIDTH-1:0]                     sat_cnt_q, sat_cnt_d;

    assign s2_en           = !s2_vld_q || data_out_0_ready;
    assign s1_en           = !s1_vld_q || s2_en;
    assign data_in_0_ready = rst && s1_en;

    for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
        logic signed [RW-1:0] x_ext;
        logic signed [RW-1:0] r;
        logic                 sat_hi, sat_lo;

        assign x_ext = {data_in_0[i*DATA_IN_WIDTH+DATA_IN_WIDTH-1],
                        data_in_0[i*DATA_IN_WIDTH +: DATA_IN_WIDTH]};

        // One guard bit keeps the half-LSB add from wrapping at the positive extreme.
        if (SHIFT > 0) begin : g_round
            localparam logic signed [RW-1:0] HALF = RW'(2**(SHIFT-1));
            logic signed [RW-1:0] sum;
            assign sum       = x_ext + HALF;
            assign s1_r_d[i] = sum >>> SHIFT;
        end else begin : g_pass
            assign s1_r_d[i] = x_ext;
        end

        assign r      = s1_r_q[i];
        assign sat_hi = r > MAXV;
        assign sat_lo = r < MINV;
        assign lane_sat[i] = sat_hi || sat_lo;
        assign s2_dat_d[i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH] =
            sat_hi ? MAXV[DATA_OUT_WIDTH-1:0] :
            sat_lo ? MINV[DATA_OUT_WIDTH-1:0] : r[DATA_OUT_WIDTH-1:0];
    end

    assign s2_sat_d = |lane_sat;

    always_comb begin
        s1_vld_d  = s1_en ? data_in_0_valid : s1_vld_q;
        s2_vld_d  = s2_en ? s1_vld_q : s2_vld_q;
        sat_cnt_d = sat_cnt_q;
        if (sat_clear) begin
            sat_cnt_d = '0;
        end else if (s2_vld_q && data_out_0_ready && s2_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + SAT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s1_r_q    <= '0;
            s2_dat_q  <= '0;
            s2_sat_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s2_vld_q  <= s2_vld_d;
            sat_cnt_q <= sat_cnt_d;
            if (s1_en) begin
                s1_r_q <= s1_r_d;
            end
            if (s2_en) begin
                s2_dat_q <= s2_dat_d;
                s2_sat_q <= s2_sat_d;
            end
        end
    end

    assign data_out_0       = s2_dat_q;
    assign data_out_0_valid = s2_vld_q;
    assign data_out_0_sat   = s2_sat_q;
    assign sat_count        = sat_cnt_q;

`ifndef SYNTHESIS
    // A stalled upstream beat must stay valid and unchanged until accepted.
    upstream_hold: assert property (@(posedge clk) disable iff (!rst)
        (data_in_0_valid && !data_in_0_ready) |=> (data_in_0_valid && $stable(data_in_0)));
`endif

endmodule
